// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-voted bits, valid/ready holding register.
// Define UART_RX_BREAK_DETECT_EN to report line breaks on break_det.
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int OVERSAMPLING = 16,
  parameter int MSB_FIRST    = 0
) (
  input  logic                 baud,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 break_det
);

  localparam int TW = $clog2(OVERSAMPLING);
  localparam int H  = OVERSAMPLING / 2;

  localparam logic [TW-1:0] TC_MAX = TW'(OVERSAMPLING - 1);
  localparam logic [TW-1:0] TAP_A  = TW'(H - 1);
  localparam logic [TW-1:0] TAP_B  = TW'(H);
  localparam logic [TW-1:0] TAP_V  = TW'(H + 1);
  localparam logic [3:0]    DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST = 4'(STOP_BITS - 1);

`ifdef UART_RX_BREAK_DETECT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;
`endif

  state_t state_q, state_d;

  logic                 rx_meta_q, rxs_q, rxs_prev_q;
  logic [TW-1:0]        tc_q, tc_d;
  logic [3:0]           bc_q, bc_d;
  logic                 t0_q, t0_d, t1_q, t1_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 ferr_q, perr_q, ovr_q, ovr_d;
  logic                 end_frame, end_ferr, end_perr, end_brk;
  logic                 vote, at_vote, wrap, good, xr, pbad;
  logic [3:0]           idx;

  assign vote    = (t0_q & t1_q) | (t0_q & rxs_q) | (t1_q & rxs_q);
  assign at_vote = (tc_q == TAP_V);
  assign wrap    = (tc_q == TC_MAX);
  assign xr      = ^sh_q;
  assign pbad    = (PARITY_MODE == 1) ? (par_q != xr) :
                   (PARITY_MODE == 2) ? (par_q == xr) : 1'b0;
  assign idx     = (MSB_FIRST != 0) ? (DB_LAST - bc_q) : bc_q;

  always_comb begin
    state_d   = state_q;
    tc_d      = tc_q;
    bc_d      = bc_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    sh_d      = sh_q;
    par_d     = par_q;
    end_frame = 1'b0;
    end_ferr  = 1'b0;
    end_perr  = 1'b0;
    end_brk   = 1'b0;

    if (state_q != S_IDLE) begin
      tc_d = wrap ? '0 : tc_q + 1'b1;
      if (tc_q == TAP_A) t0_d = rxs_q;
      if (tc_q == TAP_B) t1_d = rxs_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q && rxs_prev_q) begin
          state_d = S_START;
          tc_d    = '0;
        end
      end
      S_START: begin
        if (at_vote && vote) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          state_d = S_DATA;
          bc_d    = '0;
        end
      end
      S_DATA: begin
        if (at_vote) begin
          for (int i = 0; i < DATA_BITS; i++)
            if (idx == 4'(i)) sh_d[i] = vote;
        end
        if (wrap) begin
          if (bc_q == DB_LAST) begin
            bc_d    = '0;
            state_d = (PARITY_MODE == 0) ? S_STOP : S_PAR;
          end else begin
            bc_d = bc_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (at_vote) par_d = vote;
        if (wrap) begin
          state_d = S_STOP;
          bc_d    = '0;
        end
      end
      S_STOP: begin
        // final stop vote ends the frame early so frames may abut
        if (at_vote && (!vote || bc_q == SB_LAST)) begin
          state_d   = S_IDLE;
          end_frame = 1'b1;
          end_ferr  = !vote;
          end_perr  = pbad;
`ifdef UART_RX_BREAK_DETECT_EN
          if (!vote && bc_q == 4'd0 && sh_q == '0 &&
              (PARITY_MODE == 0 || !par_q)) begin
            state_d  = S_BRK;
            end_brk  = 1'b1;
            end_ferr = 1'b0;
            end_perr = 1'b0;
          end
`endif
        end else if (wrap) begin
          bc_d = bc_q + 1'b1;
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      S_BRK: begin
        if (rxs_q) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d   = S_IDLE;
      end_frame = 1'b0;
      end_ferr  = 1'b0;
      end_perr  = 1'b0;
      end_brk   = 1'b0;
    end
    if (state_d == S_IDLE) tc_d = '0;
  end

  assign good = end_frame & ~end_ferr & ~end_perr & ~end_brk;

  always_comb begin
    data_d = data_q;
    dv_d   = dv_q;
    ovr_d  = 1'b0;
    if (dv_q && data_ready) dv_d = 1'b0;
    if (good) begin
      if (!dv_q || data_ready) begin
        data_d = sh_q;
        dv_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge baud or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      tc_q       <= '0;
      bc_q       <= '0;
      t0_q       <= 1'b0;
      t1_q       <= 1'b0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      tc_q       <= tc_d;
      bc_q       <= bc_d;
      t0_q       <= t0_d;
      t1_q       <= t1_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      ferr_q     <= end_ferr;
      perr_q     <= end_perr;
      ovr_q      <= ovr_d;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_q;
  always_ff @(posedge baud or negedge reset_n) begin
    if (!reset_n) brk_q <= 1'b0;
    else          brk_q <= end_brk;
  end
  assign break_det = brk_q;
`else
  assign break_det = 1'b0;
`endif

  assign data        = data_q;
  assign data_valid  = dv_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_err   = ferr_q;
  assign parity_err  = perr_q;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8E1 LSB-first and 7N2 MSB-first units.
// Expected words/flags come from a frame-level model of the line bits.
module tb_uart_rx_param;

  localparam int OS = 16;

  logic       baud = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       rdy0 = 1'b1, rdy1 = 1'b1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic       dv0, busy0, fe0, pe0, oe0, bd0;
  logic       dv1, busy1, fe1, pe1, oe1, bd1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [8:0] wq0[$], wq1[$];
  logic [3:0] fq0[$], fq1[$];
  bit         full0 = 0, full1 = 0;

  uart_rx_param #(
    .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
    .OVERSAMPLING(OS), .MSB_FIRST(0)
  ) u0 (
    .baud(baud), .reset_n(reset_n), .enable(enable), .rx(rx0),
    .data(data0), .data_valid(dv0), .data_ready(rdy0), .busy(busy0),
    .frame_err(fe0), .parity_err(pe0), .overrun_err(oe0),
    .break_det(bd0)
  );

  uart_rx_param #(
    .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2),
    .OVERSAMPLING(OS), .MSB_FIRST(1)
  ) u1 (
    .baud(baud), .reset_n(reset_n), .enable(enable), .rx(rx1),
    .data(data1), .data_valid(dv1), .data_ready(rdy1), .busy(busy1),
    .frame_err(fe1), .parity_err(pe1), .overrun_err(oe1),
    .break_det(bd1)
  );

  always #5 baud = ~baud;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic extra(input string name, input logic [31:0] act);
    chk_cnt++;
    $display("FAIL %s: unexpected output %0h, nothing expected", name, act);
  endtask

  task automatic push_flags(input int dut, input logic [3:0] f);
    if (dut == 0) fq0.push_back(f);
    else          fq1.push_back(f);
  endtask

  // Frame model: line[0] is the start bit, then data, parity, stops.
  task automatic expect_frame(input int dut, input logic [31:0] line,
                              input int dbits, input int pmode,
                              input int sbits, input int msb,
                              input bit rdy);
    logic [8:0] w;
    logic pv, xr, s1, s2;
    bit fe, pe, bk, full;
    int pos;
    w = '0;
    pv = 1'b0;
    for (int i = 0; i < dbits; i++)
      w[msb != 0 ? dbits - 1 - i : i] = line[1 + i];
    xr = ^w;
    pos = 1 + dbits;
    pe = 0;
    if (pmode != 0) begin
      pv = line[pos];
      pos++;
      pe = (pmode == 1) ? (pv != xr) : (pv == xr);
    end
    s1 = line[pos];
    s2 = (sbits == 2) ? line[pos + 1] : 1'b1;
    fe = !s1 || !s2;
    bk = 0;
`ifdef UART_RX_BREAK_DETECT_EN
    bk = (w == '0) && (pmode == 0 || !pv) && !s1;
`endif
    full = (dut == 0) ? full0 : full1;
    if (bk) push_flags(dut, 4'b0001);
    else if (fe || pe) push_flags(dut, {fe, pe, 2'b00});
    else if (!full || rdy) begin
      if (dut == 0) wq0.push_back(w);
      else          wq1.push_back(w);
      if (!rdy) begin
        if (dut == 0) full0 = 1;
        else          full1 = 1;
      end
    end else push_flags(dut, 4'b0010);
  endtask

  always @(negedge baud) begin
    if (reset_n) begin
      if (dv0 && rdy0) begin
        if (wq0.size() == 0) extra("word0", {24'd0, data0});
        else check("word0", {24'd0, data0}, {23'd0, wq0.pop_front()});
      end
      if (fe0 || pe0 || oe0 || bd0) begin
        if (fq0.size() == 0) extra("flags0", {28'd0, fe0, pe0, oe0, bd0});
        else check("flags0", {28'd0, fe0, pe0, oe0, bd0},
                   {28'd0, fq0.pop_front()});
      end
      if (dv1 && rdy1) begin
        if (wq1.size() == 0) extra("word1", {25'd0, data1});
        else check("word1", {25'd0, data1}, {23'd0, wq1.pop_front()});
      end
      if (fe1 || pe1 || oe1 || bd1) begin
        if (fq1.size() == 0) extra("flags1", {28'd0, fe1, pe1, oe1, bd1});
        else check("flags1", {28'd0, fe1, pe1, oe1, bd1},
                   {28'd0, fq1.pop_front()});
      end
    end
  end

  task automatic tk(input int n);
    repeat (n) begin
      @(posedge baud);
      #1;
    end
  endtask

  task automatic send(input int dut, input logic [31:0] line, input int n);
    for (int i = 0; i < n; i++) begin
      if (dut == 0) rx0 = line[i];
      else          rx1 = line[i];
      tk(OS);
    end
    if (dut == 0) rx0 = 1'b1;
    else          rx1 = 1'b1;
  endtask

  function automatic logic [31:0] l0(input logic [7:0] d, input logic p,
                                     input logic s);
    return {21'd0, s, p, d, 1'b0};
  endfunction

  function automatic logic [31:0] l1(input logic [6:0] b, input logic s1,
                                     input logic s2);
    return {22'd0, s2, s1, b, 1'b0};
  endfunction

  initial begin
    #4_000_000;
    $display("FAIL watchdog: run did not finish, 0 expected");
    $fatal(1);
  end

  initial begin
    logic [31:0] ln;
    logic [7:0]  d;
    logic [6:0]  b;
    logic        p, s, s2;

    @(negedge baud);
    check("reset0", {16'd0, data0, dv0, busy0, fe0, pe0, oe0, bd0}, 32'd0);
    check("reset1", {17'd0, data1, dv1, busy1, fe1, pe1, oe1, bd1}, 32'd0);
    @(posedge baud);
    #1;
    reset_n = 1'b1;
    enable  = 1'b1;
    tk(5);

    ln = l0(8'hA5, 1'b0, 1'b1);
    expect_frame(0, ln, 8, 1, 1, 0, rdy0);
    send(0, ln, 11);
    tk(4);
    check("a5_data", {24'd0, data0}, 32'hA5);

    ln = l0(8'h3C, 1'b1, 1'b1);
    expect_frame(0, ln, 8, 1, 1, 0, rdy0);
    send(0, ln, 11);
    tk(4);
    check("3c_no_valid", {31'd0, dv0}, 32'd0);

    rx0 = 1'b0;
    tk(6);
    rx0 = 1'b1;
    @(negedge baud);
    check("fstart_busy", {31'd0, busy0}, 32'd1);
    tk(12);
    @(negedge baud);
    check("fstart_idle", {31'd0, busy0}, 32'd0);
    tk(1);

    rdy0 = 1'b0;
    ln = l0(8'h11, ^8'h11, 1'b1);
    expect_frame(0, ln, 8, 1, 1, 0, rdy0);
    send(0, ln, 11);
    ln = l0(8'h22, ^8'h22, 1'b1);
    expect_frame(0, ln, 8, 1, 1, 0, rdy0);
    send(0, ln, 11);
    tk(4);
    check("ovr_held", {23'd0, dv0, data0}, {23'd0, 1'b1, 8'h11});
    rdy0 = 1'b1;
    full0 = 0;
    tk(4);

    ln = l1(7'b1100101, 1'b1, 1'b1);
    expect_frame(1, ln, 7, 0, 2, 1, rdy1);
    send(1, ln, 10);
    tk(4);
    check("msb_53", {25'd0, data1}, 32'h53);
    ln = l1(7'b0110011, 1'b1, 1'b0);
    expect_frame(1, ln, 7, 0, 2, 1, rdy1);
    send(1, ln, 10);
    tk(6);

    for (int k = 0; k < 2; k++) begin
      expect_frame(0, 32'd0, 8, 1, 1, 0, rdy0);
      rx0 = 1'b0;
      tk(12 * OS);
      rx0 = 1'b1;
      tk(20);
    end

    rx0 = 1'b0;
    tk(3 * OS);
    enable = 1'b0;
    tk(2);
    rx0 = 1'b1;
    @(negedge baud);
    check("dis_idle", {31'd0, busy0}, 32'd0);
    tk(1);
    enable = 1'b1;
    tk(4);

    rx0 = 1'b0;
    tk(2 * OS + 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid", {16'd0, data0, dv0, busy0, fe0, pe0, oe0, bd0}, 32'd0);
    rx0 = 1'b1;
    @(posedge baud);
    #1;
    reset_n = 1'b1;
    tk(4);

    for (int k = 0; k < 40; k++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 7) != 0);
      ln = l0(d, p, s);
      expect_frame(0, ln, 8, 1, 1, 0, rdy0);
      send(0, ln, 11);
      tk(s ? $urandom_range(0, 6) : $urandom_range(2, 6));
    end

    for (int k = 0; k < 30; k++) begin
      b  = 7'($urandom_range(0, 127));
      s  = ($urandom_range(0, 7) != 0);
      s2 = ($urandom_range(0, 7) != 0);
      ln = l1(b, s, s2);
      expect_frame(1, ln, 7, 0, 2, 1, rdy1);
      send(1, ln, 10);
      tk(s2 ? $urandom_range(0, 6) : $urandom_range(2, 6));
    end

    tk(40);
    check("wq0_empty", wq0.size(), 32'd0);
    check("fq0_empty", fq0.size(), 32'd0);
    check("wq1_empty", wq1.size(), 32'd0);
    check("fq1_empty", fq1.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed-format receiver in the monitor FPGA datapath.
- Frame format is configurable: data width, parity mode, stop bit count and bit order.
- Each bit is decided by a mid-bit 3-tap majority vote, and false start bits are rejected.
- Received words are delivered through a valid/ready holding register.
- Framing, parity and overrun errors are reported as separate flags.
- Sits between the rx pin and the command/packet parser.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, 1 or 2
OVERSAMPLING, 16, baud ticks per bit; even, >= 8
MSB_FIRST, 0, 0 = first data bit is data[0]; 1 = first data bit is data[DATA_BITS-1]

Ports:
baud  in  1  oversampled baud clock (OVERSAMPLING x bit rate), sole clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  receiver enable
rx  in  1  serial line, asynchronous, idle high
data  out  DATA_BITS  received word, held while data_valid=1
data_valid  out  1  data holds an unconsumed word
data_ready  in  1  consumer accepts data this cycle when data_valid=1
busy  out  1  frame in progress (state != IDLE)
frame_err  out  1  one-cycle pulse: stop bit sampled 0
parity_err  out  1  one-cycle pulse: parity mismatch
overrun_err  out  1  one-cycle pulse: good frame dropped because holding register was full
break_det  out  1  one-cycle pulse: break detected; tied 0 without UART_RX_BREAK_DETECT_EN

Behaviour:
Reset:
- Asynchronous, active-low.
- All outputs 0, state IDLE, tick counter 0.
- Both rx synchroniser flops reset to 1.

Input and start detection:
- rx passes a 2-flop synchroniser (rxs), adding 2 cycles of latency.
- Start edge = rxs 0 while previous rxs 1. A line held low never triggers a start.

Bit timing and sampling:
- Tick counter tc, width $clog2(OVERSAMPLING), counts 0..OVERSAMPLING-1 within each bit, then wraps to 0 and the bit advances.
- Taps at tc = H-1, H, H+1, where H = OVERSAMPLING/2.
- Vote = majority of the 3 taps, evaluated at tc = H+1.

States:
- IDLE: on start edge -> START, tc=0.
- START: vote=1 -> IDLE silently (false start, no error flag). vote=0 -> DATA at wrap.
- DATA: DATA_BITS bits. Each vote is stored in data index order set by MSB_FIRST. -> PARITY at wrap, or STOP if PARITY_MODE=0.
- PARITY: vote compared against the XOR of the data bits; even mode expects vote = XOR, odd mode expects vote = ~XOR. -> STOP at wrap.
- STOP: every stop bit must vote 1.
  - On the vote of the final stop bit, the frame completes immediately and the receiver returns to IDLE in the same cycle, without waiting for the wrap. This allows back-to-back frames.
  - With STOP_BITS=2, a 0 on the first stop bit ends the frame at that vote with frame_err.

Frame completion (cycle after the final vote):
- Any frame or parity error: pulse the corresponding flag(s); both may pulse together. Word discarded; holding register untouched.
- Good frame, data_valid=0 or data_ready=1 this cycle: load data, data_valid=1.
- Good frame, data_valid=1 and data_ready=0: overrun_err pulse; new word dropped; held word kept.
- Handshake without a new frame: data_valid clears the cycle after data_ready=1.

enable:
- enable=0 synchronously forces IDLE and aborts any partial frame with no error flags.
- Holding register and data_valid are unaffected.
- The synchroniser keeps running while disabled.

Reset mid-frame: immediate abort; all outputs 0 (see Reset).

Optional Feature:
UART_RX_BREAK_DETECT_EN
- Defined:
  - A frame with all data bits 0, parity vote 0 (if parity enabled) and first stop vote 0 pulses break_det instead of frame_err/parity_err.
  - No word is loaded.
  - State goes to BREAK_WAIT until rxs=1, then IDLE.
- Undefined: such a frame reports frame_err (plus parity_err if the parity check also fails); break_det is tied 0; no BREAK_WAIT state.

Test Plan:
- 8E1, OVERSAMPLING=16, send 0xA5 with parity 0 and stop 1, data_ready=1 -> data=0xA5 and data_valid=1 for 1 cycle; no error flags.
- 8E1, send 0x3C with parity bit 1 (wrong) -> parity_err one pulse, data_valid stays 0.
- rx low for 6 ticks then high -> no state change beyond START, no flags, busy drops by tick 10.
- data_ready=0, send 0x11 then 0x22 back to back -> data=0x11 held, overrun_err one pulse at end of second frame.
- MSB_FIRST=1, PARITY_MODE=0, STOP_BITS=2, DATA_BITS=7, send bit sequence 1010011 -> data=7'h53; second stop bit driven 0 -> frame_err.
- With macro: rx low for 12 bit times -> break_det one pulse, no frame_err; second break_det only after rx rises and falls again. Without macro -> frame_err once, no repeat while rx stays low.
